stopwatch_fsm_timer: RTL and testbench
======================================

Name: stopwatch_fsm_timer

Overview:
Parametrised stopwatch/timer control core: a start/pause/stop FSM combined with a tick prescaler, an up/down time counter and a lap-capture register. Button inputs are level signals, debounced and synchronised upstream; the block detects their rising edges internally. It drives the display/counter datapath through o_cnt and keeps the 2-bit cnt_ctrl encoding (ENABLE/DISABLE/RESET) so existing consumers keep working.

Parameters:
CNT_W, 16, width of the time counter and the lap register
TICK_DIV, 100, clk cycles per count tick (>=1)
MAX_CNT, 9999, largest count value; up-count wraps after it, down-load saturates to it (< 2^CNT_W)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
i_start_pause  input  1  start/pause button level; rising edge acts
i_stop  input  1  stop button level; rising edge acts
i_lap  input  1  lap button level; rising edge acts
i_mode  input  1  0 = count up, 1 = count down; sampled only in IDLE
i_load_val  input  CNT_W  countdown start value
o_cnt  output  CNT_W  current count
o_lap_cnt  output  CNT_W  last captured lap value
o_lap_valid  output  1  1-cycle pulse on lap capture
o_state  output  2  IDLE=00, COUNT=01, PAUSE=10, DONE=11
o_cnt_ctrl  output  2  ENABLE=00, DISABLE=01, RESET=10
o_wrap  output  1  1-cycle pulse when up-count wraps MAX_CNT->0
o_expire  output  1  1-cycle pulse when countdown reaches 0

Behaviour:
- Reset (async, rst_n low): state IDLE, o_cnt=0, o_lap_cnt=0, all pulses 0, o_cnt_ctrl=RESET, prescaler=0, edge-detect history regs=0.
- Edge detect: edge = level & ~level_d (level_d registered). The state changes on the same clk edge that first samples the input high. A held button produces exactly one event.
- Same-cycle priority: stop > start_pause > lap.
- IDLE: the mode register loads i_mode every cycle. o_cnt = 0 (up) or min(i_load_val, MAX_CNT) (down), updated every cycle. Prescaler is held at 0.
  - start_pause edge -> COUNT.
  - Exception: down mode with loaded value 0 -> DONE, with o_expire asserted in the following cycle.
- COUNT: prescaler counts 0..TICK_DIV-1. A tick occurs when the prescaler equals TICK_DIV-1; the prescaler then returns to 0.
  - Up mode, on tick: o_cnt+1. At MAX_CNT, o_cnt wraps to 0 and o_wrap pulses.
  - Down mode, on tick: o_cnt-1. When o_cnt goes 1->0, enter DONE and pulse o_expire in the same cycle the count reaches 0.
  - start_pause edge -> PAUSE. stop edge -> IDLE.
  - lap edge: o_lap_cnt <= o_cnt (value before any same-cycle tick update); o_lap_valid pulses.
- PAUSE: o_cnt and the prescaler are held.
  - start_pause edge -> COUNT, resuming from the held prescaler value.
  - stop edge -> IDLE.
  - lap edge is ignored.
- DONE: o_cnt held at 0. Either a stop edge or a start_pause edge -> IDLE.
- Entry to IDLE clears o_lap_cnt to 0.
- o_cnt_ctrl mapping: IDLE=RESET, COUNT=ENABLE, PAUSE=DISABLE, DONE=DISABLE. Registered, so it tracks o_state with no extra latency.
- TICK_DIV=1: a tick occurs every COUNT cycle.
- Mode change while not in IDLE has no effect.

Optional Feature:
Macro STOPWATCH_DOWN_EN.
- Defined: countdown mode, i_load_val, the DONE state and o_expire are active as described above.
- Undefined: i_mode and i_load_val are ignored and the block is up-count only. DONE is unreachable and o_expire is tied 0. Ports remain present.

Test Plan:
- TICK_DIV=4, MAX_CNT=9, up mode: reset, start edge, run 40 cycles -> o_cnt steps every 4 cycles 0..9, wraps to 0 with one o_wrap pulse; o_cnt_ctrl=00 throughout COUNT.
- Pause/resume: start, pause at prescaler=2, wait 20 cycles -> o_cnt and prescaler frozen, o_cnt_ctrl=01; resume -> next tick after exactly 1 more cycle.
- Lap: in COUNT with o_cnt=5, lap edge held high for 10 cycles -> o_lap_cnt=5, single o_lap_valid pulse; lap edge in PAUSE -> no capture; stop -> o_lap_cnt=0, o_cnt=0, o_cnt_ctrl=10.
- Countdown, macro defined: i_mode=1, i_load_val=3, start -> 3,2,1,0 at 4-cycle steps, o_expire pulses once, state DONE; start edge -> IDLE. Separately, i_load_val=0 -> DONE plus expire; i_load_val=50 -> loads 9.
- Simultaneous edges: start and stop rising in the same cycle from COUNT -> IDLE. Then assert rst_n low mid-COUNT asynchronously -> all outputs take reset values immediately.
- Macro undefined: i_mode=1, i_load_val=3 -> IDLE o_cnt=0, counts up, o_expire never asserts.

Source files
------------

// File: rtl/stopwatch_fsm_timer.sv
// Stopwatch/timer core: start/pause/stop FSM, tick prescaler, up/down counter, lap capture.
// Define STOPWATCH_DOWN_EN to enable countdown mode, the DONE state and o_expire.
module stopwatch_fsm_timer #(
    parameter int CNT_W    = 16,
    parameter int TICK_DIV = 100,
    parameter int MAX_CNT  = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start_pause,
    input  logic             i_stop,
    input  logic             i_lap,
    input  logic             i_mode,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_lap_cnt,
    output logic             o_lap_valid,
    output logic [1:0]       o_state,
    output logic [1:0]       o_cnt_ctrl,
    output logic             o_wrap,
    output logic             o_expire
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] MAX_V      = CNT_W'(MAX_CNT);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
`ifdef STOPWATCH_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COUNT = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] CTRL_ENABLE  = 2'b00;
    localparam logic [1:0] CTRL_DISABLE = 2'b01;
    localparam logic [1:0] CTRL_RESET   = 2'b10;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lap_q, lap_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             lap_valid_q, lap_valid_d;
    logic             wrap_q, wrap_d;
    logic             expire_q, expire_d;
    logic             mode_q, mode_d;
    logic             sp_hist_q, sp_hist_d;
    logic             stop_hist_q, stop_hist_d;
    logic             lap_hist_q, lap_hist_d;

    logic             sp_edge, stop_edge, lap_edge;
    logic             run;
    logic [CNT_W-1:0] load_sat;

    always_comb begin
        sp_hist_d   = i_start_pause;
        stop_hist_d = i_stop;
        lap_hist_d  = i_lap;
        sp_edge     = i_start_pause & ~sp_hist_q;
        stop_edge   = i_stop & ~stop_hist_q;
        lap_edge    = i_lap & ~lap_hist_q;
        load_sat    = (i_load_val > MAX_V) ? MAX_V : i_load_val;

        state_d     = state_q;
        cnt_d       = cnt_q;
        lap_d       = lap_q;
        presc_d     = presc_q;
        mode_d      = mode_q;
        lap_valid_d = 1'b0;
        wrap_d      = 1'b0;
        expire_d    = 1'b0;
        run         = 1'b0;

        // A clock edge that leaves COUNT does not advance time; a resume edge does.
        case (state_q)
            S_IDLE: begin
                mode_d  = DOWN_EN & i_mode;
                cnt_d   = (DOWN_EN && i_mode) ? load_sat : '0;
                presc_d = '0;
                if (sp_edge) begin
                    if (DOWN_EN && i_mode && (load_sat == '0)) begin
                        state_d  = S_DONE;
                        expire_d = 1'b1;
                    end else begin
                        state_d = S_COUNT;
                    end
                end
            end
            S_COUNT: begin
                if (stop_edge) begin
                    state_d = S_IDLE;
                end else if (sp_edge) begin
                    state_d = S_PAUSE;
                end else begin
                    run = 1'b1;
                    if (lap_edge) begin
                        lap_d       = cnt_q;
                        lap_valid_d = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (stop_edge) begin
                    state_d = S_IDLE;
                end else if (sp_edge) begin
                    state_d = S_COUNT;
                    run     = 1'b1;
                end
            end
            S_DONE: begin
                cnt_d = '0;
                if (stop_edge || sp_edge) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (run) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (mode_q) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d    = '0;
                        state_d  = S_DONE;
                        expire_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else if (cnt_q >= MAX_V) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
            cnt_d   = '0;
            lap_d   = '0;
            presc_d = '0;
        end

        case (state_d)
            S_IDLE:  ctrl_d = CTRL_RESET;
            S_COUNT: ctrl_d = CTRL_ENABLE;
            default: ctrl_d = CTRL_DISABLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lap_q       <= '0;
            presc_q     <= '0;
            ctrl_q      <= CTRL_RESET;
            lap_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            expire_q    <= 1'b0;
            mode_q      <= 1'b0;
            sp_hist_q   <= 1'b0;
            stop_hist_q <= 1'b0;
            lap_hist_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lap_q       <= lap_d;
            presc_q     <= presc_d;
            ctrl_q      <= ctrl_d;
            lap_valid_q <= lap_valid_d;
            wrap_q      <= wrap_d;
            expire_q    <= expire_d;
            mode_q      <= mode_d;
            sp_hist_q   <= sp_hist_d;
            stop_hist_q <= stop_hist_d;
            lap_hist_q  <= lap_hist_d;
        end
    end

    assign o_cnt       = cnt_q;
    assign o_lap_cnt   = lap_q;
    assign o_lap_valid = lap_valid_q;
    assign o_state     = state_q;
    assign o_cnt_ctrl  = ctrl_q;
    assign o_wrap      = wrap_q;
    assign o_expire    = expire_q;

endmodule

// File: tb/tb_stopwatch_fsm_timer.sv
// Bench for stopwatch_fsm_timer (TICK_DIV=4, MAX_CNT=9): table vectors, corner sequences, random run vs model.
module tb_stopwatch_fsm_timer;
    localparam int CNT_W    = 16;
    localparam int TICK_DIV = 4;
    localparam int MAX_CNT  = 9;
    localparam int W        = 39;
`ifdef STOPWATCH_DOWN_EN
    localparam bit DOWN = 1'b1;
`else
    localparam bit DOWN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sp = 1'b0, stop = 1'b0, lap = 1'b0, mode = 1'b0;
    logic [CNT_W-1:0] load_val = '0;
    logic [CNT_W-1:0] o_cnt, o_lap_cnt;
    logic             o_lap_valid, o_wrap, o_expire;
    logic [1:0]       o_state, o_cnt_ctrl;

    stopwatch_fsm_timer #(.CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .MAX_CNT(MAX_CNT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_start_pause(sp), .i_stop(stop), .i_lap(lap),
        .i_mode(mode), .i_load_val(load_val),
        .o_cnt(o_cnt), .o_lap_cnt(o_lap_cnt), .o_lap_valid(o_lap_valid),
        .o_state(o_state), .o_cnt_ctrl(o_cnt_ctrl),
        .o_wrap(o_wrap), .o_expire(o_expire)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: state 0=idle 1=count 2=pause 3=done, time kept as plain integers.
    int m_state, m_cnt, m_lap, m_presc;
    bit m_mode, m_lv, m_wrap, m_exp;
    bit p_sp, p_stop, p_lap;

    function automatic logic [W-1:0] actual_vec();
        return {o_state, o_cnt_ctrl, o_cnt, o_lap_cnt, o_lap_valid, o_wrap, o_expire};
    endfunction

    task automatic reset_model();
        m_state = 0; m_cnt = 0; m_lap = 0; m_presc = 0;
        m_mode = 0; m_lv = 0; m_wrap = 0; m_exp = 0;
        p_sp = 0; p_stop = 0; p_lap = 0;
        exp_q.delete();
    endtask

    task automatic go_idle();
        m_state = 0; m_cnt = 0; m_lap = 0; m_presc = 0;
    endtask

    task automatic model_step();
        bit sp_e, st_e, lp_e, adv;
        int ld, ctrl;
        sp_e = sp && !p_sp;
        st_e = stop && !p_stop;
        lp_e = lap && !p_lap;
        p_sp = sp; p_stop = stop; p_lap = lap;
        m_lv = 0; m_wrap = 0; m_exp = 0; adv = 0;
        ld = (int'(load_val) > MAX_CNT) ? MAX_CNT : int'(load_val);
        case (m_state)
            0: begin
                m_mode  = DOWN && mode;
                m_presc = 0;
                m_cnt   = m_mode ? ld : 0;
                if (sp_e) begin
                    if (m_mode && ld == 0) begin m_state = 3; m_exp = 1; end
                    else m_state = 1;
                end
            end
            1: begin
                if (st_e) go_idle();
                else if (sp_e) m_state = 2;
                else begin
                    if (lp_e) begin m_lap = m_cnt; m_lv = 1; end
                    adv = 1;
                end
            end
            2: begin
                if (st_e) go_idle();
                else if (sp_e) begin m_state = 1; adv = 1; end
            end
            default: begin
                m_cnt = 0;
                if (st_e || sp_e) go_idle();
            end
        endcase
        if (adv) begin
            m_presc = (m_presc + 1) % TICK_DIV;
            if (m_presc == 0) begin
                if (m_mode) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin m_state = 3; m_exp = 1; end
                end else begin
                    m_cnt  = (m_cnt + 1) % (MAX_CNT + 1);
                    m_wrap = (m_cnt == 0);
                end
            end
        end
        ctrl = (m_state == 0) ? 2 : (m_state == 1) ? 0 : 1;
        exp_q.push_back({2'(m_state), 2'(ctrl), 16'(m_cnt), 16'(m_lap), m_lv, m_wrap, m_exp});
    endtask

    task automatic check_outputs();
        logic [W-1:0] e, a;
        a = actual_vec();
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty actual=%h", a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t actual state=%0d ctrl=%0d cnt=%0d lap=%0d lv=%0b wrap=%0b exp=%0b required state=%0d ctrl=%0d cnt=%0d lap=%0d lv=%0b wrap=%0b exp=%0b",
                         $time, a[38:37], a[36:35], a[34:19], a[18:3], a[2], a[1], a[0],
                         e[38:37], e[36:35], e[34:19], e[18:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic hcheck(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    typedef struct {
        bit sp;
        bit stop;
        bit lap;
        int n;
        int e_state;
        int e_cnt;
        int e_lap;
        bit e_wrap;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{0, 0, 0,  2, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0,  1, 1, 0, 0, 0};
        vecs[2]  = '{1, 0, 0,  3, 1, 0, 0, 0};
        vecs[3]  = '{0, 0, 0,  1, 1, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 16, 1, 5, 0, 0};
        vecs[5]  = '{0, 0, 1, 10, 1, 7, 5, 0};
        vecs[6]  = '{1, 0, 0,  1, 2, 7, 5, 0};
        vecs[7]  = '{0, 0, 1, 20, 2, 7, 5, 0};
        vecs[8]  = '{1, 0, 0,  1, 1, 7, 5, 0};
        vecs[9]  = '{0, 0, 0,  1, 1, 8, 5, 0};
        vecs[10] = '{0, 0, 0,  4, 1, 9, 5, 0};
        vecs[11] = '{0, 0, 0,  4, 1, 0, 5, 1};
        vecs[12] = '{0, 1, 0,  1, 0, 0, 0, 0};
        vecs[13] = '{0, 0, 0,  2, 0, 0, 0, 0};

        reset_model();
        repeat (3) @(negedge clk);
        hcheck("reset_outputs", 64'(actual_vec()), 64'({2'b00, 2'b10, 16'd0, 16'd0, 3'b000}));
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            sp = vecs[v].sp; stop = vecs[v].stop; lap = vecs[v].lap;
            cycle(vecs[v].n);
            hcheck($sformatf("vec%0d_state", v), 64'(o_state), 64'(vecs[v].e_state));
            hcheck($sformatf("vec%0d_cnt", v), 64'(o_cnt), 64'(vecs[v].e_cnt));
            hcheck($sformatf("vec%0d_lap", v), 64'(o_lap_cnt), 64'(vecs[v].e_lap));
            hcheck($sformatf("vec%0d_wrap", v), 64'(o_wrap), 64'(vecs[v].e_wrap));
        end

        // Start and stop edges in the same cycle from COUNT: stop wins.
        sp = 1; cycle(1);
        sp = 0; cycle(3);
        sp = 1; stop = 1; cycle(1);
        hcheck("simul_edges_state", 64'(o_state), 64'd0);
        hcheck("simul_edges_ctrl", 64'(o_cnt_ctrl), 64'd2);
        sp = 0; stop = 0; cycle(1);

        // Asynchronous reset mid-COUNT after a lap capture.
        sp = 1; cycle(1);
        sp = 0; cycle(6);
        lap = 1; cycle(1);
        lap = 0; cycle(2);
        hcheck("pre_reset_lap", 64'(o_lap_cnt), 64'd1);
        #2 rst_n = 1'b0;
        #1 hcheck("async_reset_outputs", 64'(actual_vec()), 64'({2'b00, 2'b10, 16'd0, 16'd0, 3'b000}));
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1);

`ifdef STOPWATCH_DOWN_EN
        mode = 1; load_val = 16'd3; cycle(1);
        hcheck("down_idle_load", 64'(o_cnt), 64'd3);
        sp = 1; cycle(1);
        sp = 0; cycle(12);
        hcheck("down_done_state", 64'(o_state), 64'd3);
        hcheck("down_expire", 64'(o_expire), 64'd1);
        cycle(1);
        hcheck("down_expire_once", 64'(o_expire), 64'd0);
        sp = 1; cycle(1);
        hcheck("done_to_idle", 64'(o_state), 64'd0);
        sp = 0; load_val = 16'd0; cycle(1);
        sp = 1; cycle(1);
        hcheck("zero_load_done", 64'(o_state), 64'd3);
        hcheck("zero_load_expire", 64'(o_expire), 64'd1);
        sp = 0; stop = 1; cycle(1);
        stop = 0; load_val = 16'd50; cycle(1);
        hcheck("load_saturate", 64'(o_cnt), 64'd9);
`else
        mode = 1; load_val = 16'd3; cycle(1);
        hcheck("uponly_idle_cnt", 64'(o_cnt), 64'd0);
        sp = 1; cycle(1);
        sp = 0; cycle(6);
        hcheck("uponly_counts_up", 64'(o_cnt), 64'd1);
        hcheck("uponly_no_expire", 64'(o_expire), 64'd0);
        stop = 1; cycle(1);
        stop = 0;
`endif
        mode = 0; load_val = '0; cycle(1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) sp = ~sp;
            if ($urandom_range(0, 40) == 0) stop = ~stop;
            if ($urandom_range(0, 5) == 0) lap = ~lap;
            if ($urandom_range(0, 3) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) load_val = 16'($urandom_range(0, 14));
            cycle(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
